qsfp_port_init_seq: RTL and testbench



---
 rtl/qsfp_port_init_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_qsfp_port_init_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsfp_port_init_seq.sv
// QSFP cage bring-up sequencer: for each port, pulse module reset, wait for the
// module to boot, select its I2C mux channel, poll the status byte until the
// module reports ready, then write the power-control byte. Finishes by
// deselecting every mux channel.
module qsfp_port_init_seq #(
    parameter int unsigned NUM_PORTS    = 2,
    parameter logic [7:0]  MUX_ID       = 8'hE0,
    parameter logic [7:0]  QSFP_ID      = 8'hA0,
    parameter int unsigned RST_HOLD_CYC = 3000,
    parameter int unsigned POST_RST_CYC = 600000,
    parameter int unsigned MAX_POLLS    = 16,
    parameter int unsigned TIMEOUT_CYC  = 1000000,
    parameter logic [7:0]  PWR_VAL      = 8'h01,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 start,
    output logic [NUM_PORTS-1:0] qsfp_resetn,
    output logic                 IO_CONTROL_PULSE,
    output logic                 IO_CONTROL_RW,
    output logic [7:0]           IO_CONTROL_ID,
    output logic [7:0]           IO_ADDR_ADDR,
    output logic [7:0]           IO_WDATA_WDATA,
    input  logic [7:0]           IO_RDATA_RDATA,
    input  logic                 IO_CONTROL_CMPLT,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_PORTS-1:0] port_ok,
    output logic [NUM_PORTS-1:0] port_err
);

    // Counters only ever hold 0..N-1, so $clog2(N) bits never wrap.
    localparam int unsigned DLY_MAX = (RST_HOLD_CYC > POST_RST_CYC) ? RST_HOLD_CYC : POST_RST_CYC;
    localparam int unsigned DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam int unsigned TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned POLL_W  = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;
    localparam int unsigned P_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [DLY_W-1:0]  HOLD_LAST = DLY_W'(RST_HOLD_CYC - 1);
    localparam logic [DLY_W-1:0]  WAIT_LAST = DLY_W'(POST_RST_CYC - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(MAX_POLLS - 1);
    localparam logic [P_W-1:0]    LAST_PORT = P_W'(NUM_PORTS - 1);

    typedef enum logic [3:0] {
        StIdle,
        StRstHold,
        StRstWait,
        StMuxSel,
        StRdStat,
        StWrPwr,
        StNext,
        StMuxOff,
        StDone
    } state_e;

    state_e             state_q;
    logic               auto_q;
    logic [P_W-1:0]     p_q;
    logic [DLY_W-1:0]   dly_q;
    logic [TO_W-1:0]    to_q;
    logic [POLL_W-1:0]  poll_q;
    logic               to_hit;
    logic               unused_rdata_hi;

    // Only the ready bit of the status byte matters.
    assign unused_rdata_hi = ^IO_RDATA_RDATA[7:1];

    // Last cycle an outstanding I2C request may still complete.
    assign to_hit = (to_q == TO_LAST);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q          <= StIdle;
            auto_q           <= AUTO_START;
            p_q              <= '0;
            dly_q            <= '0;
            to_q             <= '0;
            poll_q           <= '0;
            qsfp_resetn      <= '1;
            IO_CONTROL_PULSE <= 1'b0;
            IO_CONTROL_RW    <= 1'b0;
            IO_CONTROL_ID    <= 8'h00;
            IO_ADDR_ADDR     <= 8'h00;
            IO_WDATA_WDATA   <= 8'h00;
            busy             <= 1'b0;
            done             <= 1'b0;
            port_ok          <= '0;
            port_err         <= '0;
        end else begin
            IO_CONTROL_PULSE <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A start coinciding with the auto trigger launches one sequence.
                    if (start || auto_q) begin
                        auto_q      <= 1'b0;
                        p_q         <= '0;
                        poll_q      <= '0;
                        dly_q       <= '0;
                        port_ok     <= '0;
                        port_err    <= '0;
                        done        <= 1'b0;
                        busy        <= 1'b1;
                        qsfp_resetn <= ~(NUM_PORTS'(1));
                        state_q     <= StRstHold;
                    end
                end
                StRstHold: begin
                    if (dly_q == HOLD_LAST) begin
                        qsfp_resetn <= '1;
                        dly_q       <= '0;
                        state_q     <= StRstWait;
                    end else begin
                        dly_q <= dly_q + 1'b1;
                    end
                end
                StRstWait: begin
                    if (dly_q == WAIT_LAST) begin
                        IO_CONTROL_PULSE <= 1'b1;
                        IO_CONTROL_RW    <= 1'b0;
                        IO_CONTROL_ID    <= MUX_ID;
                        IO_ADDR_ADDR     <= 8'h00;
                        IO_WDATA_WDATA   <= 8'h01 << p_q;
                        to_q             <= '0;
                        state_q          <= StMuxSel;
                    end else begin
                        dly_q <= dly_q + 1'b1;
                    end
                end
                StMuxSel: begin
                    if (IO_CONTROL_CMPLT) begin
                        IO_CONTROL_PULSE <= 1'b1;
                        IO_CONTROL_RW    <= 1'b1;
                        IO_CONTROL_ID    <= QSFP_ID;
                        IO_ADDR_ADDR     <= 8'h02;
                        IO_WDATA_WDATA   <= 8'h00;
                        to_q             <= '0;
                        state_q          <= StRdStat;
                    end else if (to_hit) begin
                        port_err[p_q] <= 1'b1;
                        state_q       <= StNext;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                StRdStat: begin
                    if (IO_CONTROL_CMPLT) begin
                        if (!IO_RDATA_RDATA[0]) begin
                            IO_CONTROL_PULSE <= 1'b1;
                            IO_CONTROL_RW    <= 1'b0;
                            IO_CONTROL_ID    <= QSFP_ID;
                            IO_ADDR_ADDR     <= 8'd93;
                            IO_WDATA_WDATA   <= PWR_VAL;
                            to_q             <= '0;
                            state_q          <= StWrPwr;
                        end else if (poll_q == POLL_LAST) begin
                            port_err[p_q] <= 1'b1;
                            state_q       <= StNext;
                        end else begin
                            // Module still busy: reissue the same status read.
                            poll_q           <= poll_q + 1'b1;
                            IO_CONTROL_PULSE <= 1'b1;
                            to_q             <= '0;
                        end
                    end else if (to_hit) begin
                        port_err[p_q] <= 1'b1;
                        state_q       <= StNext;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                StWrPwr: begin
                    if (IO_CONTROL_CMPLT) begin
                        port_ok[p_q] <= 1'b1;
                        state_q      <= StNext;
                    end else if (to_hit) begin
                        port_err[p_q] <= 1'b1;
                        state_q       <= StNext;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                StNext: begin
                    if (p_q == LAST_PORT) begin
                        IO_CONTROL_PULSE <= 1'b1;
                        IO_CONTROL_RW    <= 1'b0;
                        IO_CONTROL_ID    <= MUX_ID;
                        IO_ADDR_ADDR     <= 8'h00;
                        IO_WDATA_WDATA   <= 8'h00;
                        to_q             <= '0;
                        state_q          <= StMuxOff;
                    end else begin
                        p_q         <= p_q + 1'b1;
                        poll_q      <= '0;
                        dly_q       <= '0;
                        qsfp_resetn <= ~(NUM_PORTS'(1) << (p_q + 1'b1));
                        state_q     <= StRstHold;
                    end
                end
                StMuxOff: begin
                    // Port results are already final; a timeout here just ends the run.
                    if (IO_CONTROL_CMPLT || to_hit) begin
                        state_q <= StDone;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                StDone: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_qsfp_port_init_seq.sv
// Directed bench for qsfp_port_init_seq with a cycle-based I2C responder.
`timescale 1ns/1ps
module tb_qsfp_port_init_seq;

    typedef logic [24:0] txn_t;  // {rw, id, addr, wdata}; wdata logged as 0 for reads

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       start = 1'b0;
    logic [1:0] qsfp_resetn;
    logic       IO_CONTROL_PULSE;
    logic       IO_CONTROL_RW;
    logic [7:0] IO_CONTROL_ID;
    logic [7:0] IO_ADDR_ADDR;
    logic [7:0] IO_WDATA_WDATA;
    logic [7:0] IO_RDATA_RDATA;
    logic       IO_CONTROL_CMPLT;
    logic       busy;
    logic       done;
    logic [1:0] port_ok;
    logic [1:0] port_err;

    qsfp_port_init_seq #(
        .NUM_PORTS   (2),
        .MUX_ID      (8'hE0),
        .QSFP_ID     (8'hA0),
        .RST_HOLD_CYC(4),
        .POST_RST_CYC(8),
        .MAX_POLLS   (16),
        .TIMEOUT_CYC (50),
        .PWR_VAL     (8'h01),
        .AUTO_START  (1'b1)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .start           (start),
        .qsfp_resetn     (qsfp_resetn),
        .IO_CONTROL_PULSE(IO_CONTROL_PULSE),
        .IO_CONTROL_RW   (IO_CONTROL_RW),
        .IO_CONTROL_ID   (IO_CONTROL_ID),
        .IO_ADDR_ADDR    (IO_ADDR_ADDR),
        .IO_WDATA_WDATA  (IO_WDATA_WDATA),
        .IO_RDATA_RDATA  (IO_RDATA_RDATA),
        .IO_CONTROL_CMPLT(IO_CONTROL_CMPLT),
        .busy            (busy),
        .done            (done),
        .port_ok         (port_ok),
        .port_err        (port_err)
    );

    always #5 aclk = ~aclk;

    txn_t       log_q[$];
    txn_t       exp_norm[$];
    int         cyc = 0;
    int         busy_reads = 0;
    int         next_delay = 5;
    int         cd = 0;
    logic [7:0] pend_rdata = 8'h00;
    int         low_cnt[2];
    int         pulses_in_rst = 0;
    int         rise_cyc = -1;
    int         first_pulse_cyc = -1;
    logic       prev_rn0 = 1'b1;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // I2C responder and monitor, sampled 1 ns after each rising edge.
    initial begin : i2c_model
        IO_CONTROL_CMPLT = 1'b0;
        IO_RDATA_RDATA   = 8'h00;
        forever begin
            @(posedge aclk);
            #1;
            cyc++;
            IO_CONTROL_CMPLT = 1'b0;
            IO_RDATA_RDATA   = 8'h00;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    IO_CONTROL_CMPLT = 1'b1;
                    IO_RDATA_RDATA   = pend_rdata;
                end
            end
            if (!aresetn && IO_CONTROL_PULSE) pulses_in_rst++;
            for (int i = 0; i < 2; i++) if (!qsfp_resetn[i]) low_cnt[i]++;
            if (!prev_rn0 && qsfp_resetn[0] && rise_cyc < 0) rise_cyc = cyc;
            prev_rn0 = qsfp_resetn[0];
            if (IO_CONTROL_PULSE) begin
                if (log_q.size() == 0) first_pulse_cyc = cyc;
                log_q.push_back({IO_CONTROL_RW, IO_CONTROL_ID, IO_ADDR_ADDR,
                                 IO_CONTROL_RW ? 8'h00 : IO_WDATA_WDATA});
                pend_rdata = 8'h00;
                if (IO_CONTROL_RW && busy_reads > 0) begin
                    pend_rdata = 8'h01;
                    busy_reads--;
                end
                cd = next_delay;
                next_delay = 5;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear_log();
        log_q.delete();
        low_cnt[0] = 0;
        low_cnt[1] = 0;
        pulses_in_rst = 0;
        rise_cyc = -1;
        first_pulse_cyc = -1;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!(done && !busy) && k < 3000) begin
            tick(1);
            k++;
        end
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic check_log(input string tag, input txn_t exp_q[$]);
        check_eq({tag, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check_eq($sformatf("%s_txn%0d", tag, i), {7'd0, log_q[i]}, {7'd0, exp_q[i]});
    endtask

    // Status reads issued while the mux selects the given port.
    function automatic int reads_for_port(input int port);
        logic [7:0] sel = 8'h00;
        logic [7:0] want;
        int n = 0;
        want = 8'h01 << port;
        foreach (log_q[i]) begin
            if (!log_q[i][24] && log_q[i][23:16] == 8'hE0 && log_q[i][15:8] == 8'h00)
                sel = log_q[i][7:0];
            else if (log_q[i][24] && sel == want)
                n++;
        end
        return n;
    endfunction

    initial begin : main
        int k;
        exp_norm = '{{1'b0, 8'hE0, 8'h00, 8'h01}, {1'b1, 8'hA0, 8'h02, 8'h00},
                     {1'b0, 8'hA0, 8'h5D, 8'h01}, {1'b0, 8'hE0, 8'h00, 8'h02},
                     {1'b1, 8'hA0, 8'h02, 8'h00}, {1'b0, 8'hA0, 8'h5D, 8'h01},
                     {1'b0, 8'hE0, 8'h00, 8'h00}};
        clear_log();

        // Reset values
        tick(3);
        check_eq("rst_qsfp_resetn", {30'd0, qsfp_resetn}, 32'h3);
        check_eq("rst_busy_done", {30'd0, busy, done}, 32'h0);
        check_eq("rst_io_outs", {7'd0, IO_CONTROL_PULSE, IO_CONTROL_RW, IO_CONTROL_ID,
                                 IO_ADDR_ADDR, IO_WDATA_WDATA}, 32'h0);
        check_eq("rst_port_res", {28'd0, port_ok, port_err}, 32'h0);

        // Auto-start, all modules ready at first read
        aresetn = 1'b1;
        wait_done("auto");
        check_log("auto", exp_norm);
        check_eq("auto_port_ok", {30'd0, port_ok}, 32'h3);
        check_eq("auto_port_err", {30'd0, port_err}, 32'h0);
        check_eq("auto_hold0_cycles", low_cnt[0], 4);
        check_eq("auto_hold1_cycles", low_cnt[1], 4);
        check_eq("auto_post_rst_gap", first_pulse_cyc - rise_cyc, 8);

        // Status busy three times on port 0
        clear_log();
        busy_reads = 3;
        pulse_start();
        wait_done("poll");
        check_eq("poll_reads_p0", reads_for_port(0), 4);
        check_eq("poll_reads_p1", reads_for_port(1), 1);
        check_eq("poll_count", log_q.size(), 10);
        if (log_q.size() > 5) check_eq("poll_wrpwr", {7'd0, log_q[5]}, {7'd0, 1'b0, 8'hA0, 8'h5D, 8'h01});
        check_eq("poll_port_ok", {30'd0, port_ok}, 32'h3);
        check_eq("poll_port_err", {30'd0, port_err}, 32'h0);

        // Port 0 never becomes ready
        clear_log();
        busy_reads = 16;
        pulse_start();
        wait_done("exh");
        check_eq("exh_reads_p0", reads_for_port(0), 16);
        check_eq("exh_reads_p1", reads_for_port(1), 1);
        check_eq("exh_count", log_q.size(), 21);
        check_eq("exh_port_ok", {30'd0, port_ok}, 32'h2);
        check_eq("exh_port_err", {30'd0, port_err}, 32'h1);

        // Port 0 mux select completes only after the timeout
        clear_log();
        busy_reads = 0;
        next_delay = 60;
        pulse_start();
        k = 0;
        while (!IO_CONTROL_PULSE && k < 100) begin
            tick(1);
            k++;
        end
        check_eq("to_pulse_seen", {31'd0, IO_CONTROL_PULSE}, 32'd1);
        tick(49);
        check_eq("to_err_before", {30'd0, port_err}, 32'h0);
        tick(1);
        check_eq("to_err_at", {30'd0, port_err}, 32'h1);
        wait_done("to");
        check_eq("to_count", log_q.size(), 5);
        if (log_q.size() > 1) check_eq("to_mux_p1", {7'd0, log_q[1]}, {7'd0, 1'b0, 8'hE0, 8'h00, 8'h02});
        check_eq("to_port_ok", {30'd0, port_ok}, 32'h2);
        check_eq("to_port_err", {30'd0, port_err}, 32'h1);

        // Start while busy is ignored
        clear_log();
        pulse_start();
        k = 0;
        while (log_q.size() < 4 && k < 500) begin
            tick(1);
            k++;
        end
        pulse_start();
        wait_done("sb");
        check_log("sb", exp_norm);
        check_eq("sb_port_ok", {30'd0, port_ok}, 32'h3);

        // Start after done clears results
        pulse_start();
        check_eq("restart_state", {28'd0, port_ok, busy, done}, 32'h2);

        // Reset during port 1 module reset hold
        k = 0;
        while (qsfp_resetn != 2'b01 && k < 500) begin
            tick(1);
            k++;
        end
        check_eq("rm_port1_hold", {30'd0, qsfp_resetn}, 32'h1);
        clear_log();
        aresetn = 1'b0;
        #1;
        check_eq("rm_qsfp_resetn", {30'd0, qsfp_resetn}, 32'h3);
        check_eq("rm_busy_ok", {29'd0, busy, port_ok}, 32'h0);
        tick(10);
        check_eq("rm_pulses_in_rst", pulses_in_rst, 0);
        check_eq("rm_no_txn", log_q.size(), 0);
        aresetn = 1'b1;
        wait_done("rm_auto");
        check_log("rm_auto", exp_norm);
        check_eq("rm_port_ok", {30'd0, port_ok}, 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
